// File: rtl/gray_counter_param.sv
// ----------------------------------------------------------------------------
// GrayCounterParam
//
// Purpose:
//   A WIDTH-bit up/down binary counter with a registered Gray-coded copy.
//   It can load a Gray value in parallel. At the count limits it either wraps
//   around or holds (saturates). It also provides terminal-count and
//   wrap-pulse indicators.
//   The Gray register is written from the same next-count value as the
//   binary register. As a result, gray_out changes exactly one bit per step,
//   which makes it safe to synchronise into another clock domain (for
//   example, as an async FIFO pointer).
//
// Parameters:
//   WIDTH       - counter width in bits (>= 2)
//   SATURATE    - 0: wrap around at the limits, 1: hold at the limits
//   RESET_VALUE - binary value loaded on reset
//
// Ports:
//   clk       in   1      clock, rising edge
//   reset     in   1      synchronous, active-high reset
//   enable    in   1      take one count step this cycle
//   up_down   in   1      count direction: 1 = up, 0 = down
//   load      in   1      load load_gray this cycle (beats enable)
//   load_gray in   WIDTH  Gray-coded value to load
//   bin_out   out  WIDTH  registered binary count
//   gray_out  out  WIDTH  registered Gray code of bin_out
//   tc        out  1      combinational terminal count for current direction
//   wrap      out  1      registered one-cycle pulse after a wrap-around
// ----------------------------------------------------------------------------
module gray_counter_param #(
    parameter int               WIDTH       = 8,
    parameter bit               SATURATE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_loadBin;
    logic [WIDTH-1:0] w_nextBin;
    logic [WIDTH-1:0] w_nextGray;
    logic             w_nextWrap;
    logic             w_atLimit;

    // Gray-to-binary conversion. Each binary bit is the XOR of all Gray bits
    // at or above it. The loop runs from the MSB down.
    function automatic logic [WIDTH-1:0] grayToBin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_loadBin = grayToBin(load_gray);

    // The limit depends on the direction. It drives both tc and the
    // wrap/saturate decision, so tc stays independent of enable and SATURATE.
    assign w_atLimit = up_down ? (r_bin == MAX_COUNT) : (r_bin == '0);

    // Next-state selection. Priority is load, then enable, then hold.
    // Reset is handled in the register block.
    // The Gray value is always derived from the chosen next binary value, so
    // the two registers can never disagree after an edge.
    always_comb begin
        w_nextBin  = r_bin;
        w_nextWrap = 1'b0;
        if (load) begin
            w_nextBin = w_loadBin;
        end else if (enable) begin
            if (!w_atLimit) begin
                w_nextBin = up_down ? (r_bin + ONE) : (r_bin - ONE);
            end else if (!SATURATE) begin
                w_nextBin  = up_down ? '0 : MAX_COUNT;
                w_nextWrap = 1'b1;
            end
        end
        w_nextGray = w_nextBin ^ (w_nextBin >> 1);
    end

    // State registers. Synchronous reset has the highest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin  <= RESET_VALUE;
            r_gray <= RESET_VALUE ^ (RESET_VALUE >> 1);
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_nextBin;
            r_gray <= w_nextGray;
            r_wrap <= w_nextWrap;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign wrap     = r_wrap;
    assign tc       = w_atLimit;

endmodule

// File: tb/tb_gray_counter_param.sv
// ----------------------------------------------------------------------------
// tb_gray_counter_param
//
// Drives three counter configurations from one shared set of inputs:
//   u_a : WIDTH=8, wrapping,   reset value 0x00
//   u_b : WIDTH=8, saturating, reset value 0x10
//   u_c : WIDTH=4, wrapping,   reset value 0x0
// Each configuration has its own reference model. The model tracks the
// count as a plain integer and applies the counting rules with modulo
// arithmetic.
// ----------------------------------------------------------------------------
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       upDown;
    logic       load;
    logic [7:0] loadGray;

    logic [7:0] binA, grayA, binB, grayB;
    logic [3:0] binC, grayC;
    logic       tcA, tcB, tcC, wrapA, wrapB, wrapC;

    int compareCount  = 0;
    int mismatchCount = 0;

    int mBin[3];
    int mWrap[3];
    int prevGray[3];
    bit mStepped[3];
    int mWidth[3] = '{8, 8, 4};
    int mSat[3]   = '{0, 1, 0};
    int mReset[3] = '{0, 16, 0};
    bit modelValid = 1'b0;

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(8), .SATURATE(1'b0), .RESET_VALUE(8'h00)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .up_down(upDown),
        .load(load), .load_gray(loadGray),
        .bin_out(binA), .gray_out(grayA), .tc(tcA), .wrap(wrapA)
    );

    gray_counter_param #(.WIDTH(8), .SATURATE(1'b1), .RESET_VALUE(8'h10)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .up_down(upDown),
        .load(load), .load_gray(loadGray),
        .bin_out(binB), .gray_out(grayB), .tc(tcB), .wrap(wrapB)
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(4'h0)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .up_down(upDown),
        .load(load), .load_gray(loadGray[3:0]),
        .bin_out(binC), .gray_out(grayC), .tc(tcC), .wrap(wrapC)
    );

    function automatic int obsBin(input int k);
        case (k)
            0:       return int'(binA);
            1:       return int'(binB);
            default: return int'(binC);
        endcase
    endfunction

    function automatic int obsGray(input int k);
        case (k)
            0:       return int'(grayA);
            1:       return int'(grayB);
            default: return int'(grayC);
        endcase
    endfunction

    function automatic int obsTc(input int k);
        case (k)
            0:       return int'(tcA);
            1:       return int'(tcB);
            default: return int'(tcC);
        endcase
    endfunction

    function automatic int obsWrap(input int k);
        case (k)
            0:       return int'(wrapA);
            1:       return int'(wrapB);
            default: return int'(wrapC);
        endcase
    endfunction

    function automatic int grayOf(input int v);
        return v ^ (v >> 1);
    endfunction

    // A binary value is the XOR of its Gray code shifted right by every amount.
    function automatic int grayToBin(input int g);
        int b = 0;
        while (g != 0) begin
            b = b ^ g;
            g = g >> 1;
        end
        return b;
    endfunction

    function automatic int modelTc(input int k);
        int limit = (1 << mWidth[k]) - 1;
        return upDown ? int'(mBin[k] == limit) : int'(mBin[k] == 0);
    endfunction

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advances every reference model by one clock edge, using the current inputs.
    task automatic modelEdge();
        for (int k = 0; k < 3; k++) begin
            int limit = (1 << mWidth[k]) - 1;
            prevGray[k] = grayOf(mBin[k]);
            mStepped[k] = 1'b0;
            if (reset) begin
                mBin[k]  = mReset[k];
                mWrap[k] = 0;
            end else if (load) begin
                mBin[k]  = grayToBin(int'(loadGray) & limit);
                mWrap[k] = 0;
            end else if (enable) begin
                mWrap[k] = 0;
                if (upDown) begin
                    if (mBin[k] < limit) begin
                        mBin[k]++;
                        mStepped[k] = 1'b1;
                    end else if (mSat[k] == 0) begin
                        mBin[k]     = 0;
                        mWrap[k]    = 1;
                        mStepped[k] = 1'b1;
                    end
                end else begin
                    if (mBin[k] > 0) begin
                        mBin[k]--;
                        mStepped[k] = 1'b1;
                    end else if (mSat[k] == 0) begin
                        mBin[k]     = limit;
                        mWrap[k]    = 1;
                        mStepped[k] = 1'b1;
                    end
                end
            end else begin
                mWrap[k] = 0;
            end
        end
        modelValid = 1'b1;
    endtask

    task automatic checkAll(input string phase);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s_bin%0d", phase, k), obsBin(k), mBin[k]);
            checkOutput($sformatf("%s_gray%0d", phase, k), obsGray(k), grayOf(mBin[k]));
            checkOutput($sformatf("%s_wrap%0d", phase, k), obsWrap(k), mWrap[k]);
            checkOutput($sformatf("%s_tc%0d", phase, k), obsTc(k), modelTc(k));
            if (mStepped[k]) begin
                checkOutput($sformatf("%s_hamming%0d", phase, k),
                            $countones(obsGray(k) ^ prevGray[k]), 1);
            end
        end
    endtask

    // Drives one cycle of inputs. It checks tc in the same cycle, then checks
    // every output just after the clock edge.
    task automatic applyStimulus(input logic rst, input logic ld, input logic [7:0] lg,
                                 input logic en, input logic ud, input string phase);
        reset    = rst;
        load     = ld;
        loadGray = lg;
        enable   = en;
        upDown   = ud;
        #1;
        if (modelValid) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("%s_tcpre%0d", phase, k), obsTc(k), modelTc(k));
            end
        end
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(phase);
    endtask

    initial begin
        logic ud;
        reset    = 1'b0;
        load     = 1'b0;
        loadGray = 8'h00;
        enable   = 1'b0;
        upDown   = 1'b1;

        // Reset together with load and enable: reset must win.
        applyStimulus(1'b1, 1'b1, 8'hC5, 1'b1, 1'b1, "rst");
        checkOutput("rstA_bin", int'(binA), 'h00);
        checkOutput("rstB_bin", int'(binB), 'h10);
        checkOutput("rstB_gray", int'(grayB), 'h18);

        // 255 steps up, then the wrapping step.
        for (int i = 0; i < 255; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "up");
        checkOutput("upA_bin_ff", int'(binA), 'hFF);
        checkOutput("upA_gray_80", int'(grayA), 'h80);
        checkOutput("upA_tc", int'(tcA), 1);
        checkOutput("upB_sat_ff", int'(binB), 'hFF);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "upwrap");
        checkOutput("upA_wrap_bin", int'(binA), 'h00);
        checkOutput("upA_wrap_pulse", int'(wrapA), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "idle");
        checkOutput("upA_wrap_cleared", int'(wrapA), 0);

        // One step down from reset.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "rst");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "down");
        checkOutput("downA_bin", int'(binA), 'hFF);
        checkOutput("downA_gray", int'(grayA), 'h80);
        checkOutput("downA_wrap", int'(wrapA), 1);

        // Load zero, then step down: the saturating counter holds at zero.
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "ld0");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "satdown");
        checkOutput("satB_bin", int'(binB), 'h00);
        checkOutput("satB_wrap", int'(wrapB), 0);
        checkOutput("satB_tc", int'(tcB), 1);

        // Load beats enable.
        applyStimulus(1'b0, 1'b1, 8'hC5, 1'b1, 1'b1, "ldC5");
        checkOutput("ldA_bin", int'(binA), 'h86);
        checkOutput("ldA_gray", int'(grayA), 'hC5);
        checkOutput("ldA_wrap", int'(wrapA), 0);

        // Count to 5, hold for three cycles, then step down once.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "rst");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "to5");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "hold");
        checkOutput("holdA_bin", int'(binA), 'h05);
        checkOutput("holdA_gray", int'(grayA), 'h07);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "back");
        checkOutput("backA_bin", int'(binA), 'h04);
        checkOutput("backA_gray", int'(grayA), 'h06);

        // Four-bit counter: 16 steps up wrap exactly once.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "rst");
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "c16");
        checkOutput("c16C_gray_8", int'(grayC), 'h8);
        checkOutput("c16C_nowrap", int'(wrapC), 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "c16last");
        checkOutput("c16C_gray_0", int'(grayC), 'h0);
        checkOutput("c16C_wrap", int'(wrapC), 1);

        // Random traffic. Direction is held for stretches so the limits get hit.
        ud = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            logic rst, ld, en;
            logic [7:0] lg;
            if ($urandom_range(15) == 0) ud = ~ud;
            rst = ($urandom_range(59) == 0);
            ld  = ($urandom_range(19) == 0);
            en  = ($urandom_range(3) != 0);
            lg  = 8'($urandom);
            applyStimulus(rst, ld, lg, en, ud, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/gray_counter_param.md
# gray_counter_param

Parametrised binary/Gray counter that keeps a WIDTH-bit binary count and a registered Gray-coded copy of it. It adds up/down counting, parallel load of a Gray value, selectable wrap or saturate at the limits, and terminal-count and wrap indicators. The registered Gray output changes exactly one bit per step, so it is safe to feed synchronisers and pointer comparators in clock-domain-crossing logic such as async FIFO pointers.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; must be at least 2.
- SATURATE, 0, limit behaviour: 0 = wrap around, 1 = hold at the limit.
- RESET_VALUE, 0, binary value loaded on reset; must be below 2^WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count one step this cycle.
- up_down  input  1  direction: 1 = up, 0 = down.
- load  input  1  load load_gray this cycle.
- load_gray  input  WIDTH  Gray-coded value to load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of bin_out.
- tc  output  1  combinational terminal count for the current direction.
- wrap  output  1  registered one-cycle pulse after a wrap-around.

## Operation
- State: the binary register b, the Gray register g and the wrap register. g always equals b ^ (b >> 1); both are computed from the same next-b value and written on the same edge.
- Priority per edge is reset, then load, then enable, then hold.
- reset: b <= RESET_VALUE, g <= gray(RESET_VALUE), wrap <= 0.
- load (with reset low): b <= gray2bin(load_gray), where b[WIDTH-1] = load_gray[WIDTH-1] and b[i] = b[i+1] ^ load_gray[i]. g <= load_gray and wrap <= 0. enable and up_down are ignored that cycle.
- enable with up_down=1:
  - If b < 2^WIDTH-1, b <= b+1.
  - At b = 2^WIDTH-1 with SATURATE=0: b <= 0 and wrap <= 1.
  - At b = 2^WIDTH-1 with SATURATE=1: b holds and wrap <= 0.
- enable with up_down=0:
  - If b > 0, b <= b-1.
  - At b = 0 with SATURATE=0: b <= 2^WIDTH-1 and wrap <= 1.
  - At b = 0 with SATURATE=1: b holds and wrap <= 0.
- enable low (with reset and load low): b and g hold, wrap <= 0.
- Arithmetic is modulo 2^WIDTH with no carry-out. Every enabled non-saturated step changes exactly one bit of gray_out, including the wrap step.
- tc = up_down ? (b == 2^WIDTH-1) : (b == 0). It is independent of enable and SATURATE.
- Reset, load or enable may arrive mid-sequence. There is no partial-operation state to discard.

## Timing
- Reset values: bin_out = RESET_VALUE, gray_out = gray(RESET_VALUE), wrap = 0. tc follows from those values and up_down.
- Latency: an input sampled at edge N is visible on bin_out, gray_out and wrap after edge N. One step is taken per enabled cycle, at full clock rate.
- wrap is high for exactly the one cycle after the wrapping edge. Back-to-back wraps are possible only for WIDTH-bit sequences that actually re-reach the limit.
- tc is combinational from b and up_down. A change of up_down updates tc in the same cycle.
- bin_out and gray_out never disagree on any cycle. No output glitches, since all are register-driven except tc.

## Test plan
- Reset with defaults, then 255 enables with up_down=1:
  - gray_out steps 0x00, 0x01, 0x03, 0x02, 0x06 … with Hamming distance 1 per step.
  - After step 255, bin_out=0xFF, gray_out=0x80, tc=1.
  - The next enable gives bin_out=0x00, gray_out=0x00, and wrap=1 for one cycle.
- From reset, one enable with up_down=0:
  - SATURATE=0: bin_out=0xFF, gray_out=0x80, wrap=1.
  - SATURATE=1: bin_out stays 0x00, wrap=0, tc=1.
- load=1 with load_gray=0xC5 and enable=1 -> bin_out=0x86, gray_out=0xC5, wrap=0. load wins over enable.
- reset=1, load=1 and enable=1 in the same cycle with RESET_VALUE=0x10 -> bin_out=0x10, gray_out=0x18.
- Count up to bin_out=0x05 (gray 0x07), drop enable for 3 cycles (values hold), then enable with up_down=0 -> bin_out=0x04, gray_out=0x06.
- WIDTH=4, SATURATE=0, up from 0 for 16 enables -> wrap pulses once at the 16th edge, and the gray sequence ends 0x8 -> 0x0.
